// File: rtl/lsu_seq.sv
// Load/store sequencer: turns one core load/store into one or two word-aligned
// memory accesses over a req/ack handshake. It lane-shifts store data, merges
// the returned words and sign- or zero-extends load results.
module lsu_seq #(
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Req,
    input  logic        IsStore,
    input  logic [2:0]  LdStrSrc,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic        Busy,
    output logic        Done,
    output logic        Err,
    output logic [31:0] LoadExt,
    output logic        MemReq,
    output logic        MemWe,
    output logic [31:0] MemAddr,
    output logic [3:0]  MemByteEn,
    output logic [31:0] MemWData,
    input  logic        MemAck,
    input  logic [31:0] MemRData
);

    typedef enum logic [1:0] {S_IDLE, S_ACC1, S_ACC2, S_DONE} state_t;

    state_t      state_q, state_d;
    logic        busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [31:0] load_ext_q, load_ext_d, mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, w0_q, w0_d;
    logic [2:0]  src_q, src_d;
    logic        store_q, store_d;

    logic [31:0] cur_addr, cur_wdata, w0_sel, w1_sel, raw32;
    logic [2:0]  cur_src, size3;
    logic        cur_store, split, illegal, finish;
    logic [1:0]  off;
    logic [3:0]  lane_mask;
    logic [7:0]  mask8;
    logic [63:0] wshift;

    // Extend the right-justified load bytes according to the access type.
    function automatic logic [31:0] ext_load(input logic [2:0] src, input logic [31:0] raw);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = raw[7:0];
        h = raw[15:0];
        case (src[1:0])
            2'b00:   ext_load = src[2] ? {24'b0, raw[7:0]}  : 32'(b);
            2'b01:   ext_load = src[2] ? {16'b0, raw[15:0]} : 32'(h);
            default: ext_load = raw;
        endcase
    endfunction

    // Access geometry: live inputs while accepting, latched copy afterwards.
    // mask8/wshift hold both accesses: low half is the first word, high half the second.
    always_comb begin
        cur_addr  = (state_q == S_IDLE) ? Addr      : addr_q;
        cur_src   = (state_q == S_IDLE) ? LdStrSrc  : src_q;
        cur_store = (state_q == S_IDLE) ? IsStore   : store_q;
        cur_wdata = (state_q == S_IDLE) ? WriteData : wdata_q;
        off       = cur_addr[1:0];
        case (cur_src[1:0])
            2'b00:   begin size3 = 3'd1; lane_mask = 4'b0001; end
            2'b01:   begin size3 = 3'd2; lane_mask = 4'b0011; end
            default: begin size3 = 3'd4; lane_mask = 4'b1111; end
        endcase
        case (cur_src)
            3'b000, 3'b001, 3'b010: illegal = 1'b0;
            3'b100, 3'b101:         illegal = cur_store;
            default:                illegal = 1'b1;
        endcase
        split  = ({1'b0, off} + size3) > 3'd4;
        mask8  = {4'b0000, lane_mask} << off;
        wshift = {32'b0, cur_wdata} << {off, 3'b000};
        w0_sel = (state_q == S_ACC1) ? MemRData : w0_q;
        w1_sel = (state_q == S_ACC2) ? MemRData : 32'b0;
        raw32  = 32'({w1_sel, w0_sel} >> {off, 3'b000});
    end

    // Next-state and registered-output computation for the access sequence.
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        load_ext_d  = load_ext_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        addr_d      = addr_q;
        src_d       = src_q;
        store_d     = store_q;
        wdata_d     = wdata_q;
        w0_d        = w0_q;
        finish      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Req) begin
                    addr_d  = Addr;
                    src_d   = LdStrSrc;
                    store_d = IsStore;
                    wdata_d = WriteData;
                    if (illegal || (split && !ALLOW_MISALIGNED)) begin
                        state_d    = S_DONE;
                        done_d     = 1'b1;
                        err_d      = 1'b1;
                        load_ext_d = 32'b0;
                    end else begin
                        state_d     = S_ACC1;
                        busy_d      = 1'b1;
                        mem_req_d   = 1'b1;
                        mem_we_d    = IsStore;
                        mem_addr_d  = {Addr[31:2], 2'b00};
                        mem_be_d    = mask8[3:0];
                        mem_wdata_d = wshift[31:0];
                    end
                end
            end
            S_ACC1: begin
                if (MemAck) begin
                    w0_d = MemRData;
                    if (split) begin
                        state_d     = S_ACC2;
                        mem_addr_d  = mem_addr_q + 32'd4;
                        mem_be_d    = mask8[7:4];
                        mem_wdata_d = wshift[63:32];
                    end else begin
                        finish = 1'b1;
                    end
                end
            end
            S_ACC2: begin
                if (MemAck) finish = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        if (finish) begin
            state_d   = S_DONE;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
            if (!store_q) load_ext_d = ext_load(src_q, raw32);
        end
    end

    // Control and visible outputs; reset aborts any access immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            load_ext_q  <= 32'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'b0;
            mem_be_q    <= 4'b0;
            mem_wdata_q <= 32'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            load_ext_q  <= load_ext_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Latched request and first returned word; only read while an access is live.
    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        src_q   <= src_d;
        store_q <= store_d;
        wdata_q <= wdata_d;
        w0_q    <= w0_d;
    end

    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Err       = err_q;
    assign LoadExt   = load_ext_q;
    assign MemReq    = mem_req_q;
    assign MemWe     = mem_we_q;
    assign MemAddr   = mem_addr_q;
    assign MemByteEn = mem_be_q;
    assign MemWData  = mem_wdata_q;

endmodule
